// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_sequencer: handshake-driven, stall-aware program counter and fetch FSM  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        exc,
    input  logic        halt,
    output logic [31:0] pc_out,
    output logic [31:0] epc,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic [31:0] r_instr;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_epc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;

    assign w_pc4     = r_pc + 32'd4;
    assign w_br_tgt  = w_pc4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign w_jmp_tgt = {w_pc4[31:28], jump_index, 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_instr_nxt = r_instr;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Redirect inputs only matter on the releasing cycle.
                if (!stall) begin
                    if (exc) begin
                        w_epc_nxt = r_pc;
                        w_pc_nxt  = EXC_VECTOR;
                    end else if (jump) begin
                        w_pc_nxt = w_jmp_tgt;
                    end else if (branch_taken) begin
                        w_pc_nxt = w_br_tgt;
                    end else begin
                        w_pc_nxt = w_pc4;
                    end
                    w_state_nxt = halt ? S_HALTED : S_FETCH;
                end
            end
            S_HALTED: begin
                w_state_nxt = S_HALTED;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_VECTOR;
            r_epc   <= 32'd0;
            r_instr <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
            r_instr <= w_instr_nxt;
        end
    end

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign pc_out      = r_pc;
    assign epc         = r_epc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == S_ISSUE);
    assign halted      = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter and sequences instruction fetch for the single-issue MIPS core. It issues word-aligned requests to instruction memory over a req/ack handshake and presents each fetched instruction to decode. It then selects the next PC from sequential, branch, jump or exception sources once decode releases the instruction. It replaces the free-running PC register with a stall-aware, handshake-driven sequencer.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception; bits [1:0] must be 0

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset; synchronous and active-low
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; always equals pc_out
- imem_ack  input  1  memory returns imem_rdata this cycle
- imem_rdata  input  32  instruction word
- instr  output  32  captured instruction for decode
- instr_valid  output  1  instr is valid and awaiting release
- stall  input  1  decode/execute not ready; holds the current instruction
- branch_taken  input  1  redirect to branch target
- branch_offset  input  16  signed word offset
- jump  input  1  redirect to jump target
- jump_index  input  26  jump word index
- exc  input  1  exception raised by the current instruction
- halt  input  1  stop fetching permanently
- pc_out  output  32  PC of the instruction being fetched or issued
- epc  output  32  PC of the last excepting instruction
- halted  output  1  sequencer is in HALTED

## Operation
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE: entered on reset. Moves to FETCH on the next cycle.
- FETCH:
  - imem_req=1, with imem_addr=pc held stable.
  - On imem_ack=1: instr<=imem_rdata and go to ISSUE.
  - Otherwise stay in FETCH; there is no timeout.
- ISSUE:
  - instr_valid=1 and imem_req=0; imem_ack is ignored.
  - stall=1: hold every register and output.
  - stall=0: the control inputs are sampled this cycle and pc is updated. Then go to FETCH, or to HALTED if halt=1.
- Next-PC priority when stall=0 in ISSUE: exc > jump > branch_taken > sequential.
  - exc: epc<=pc, pc<=EXC_VECTOR.
  - jump: pc<={pc4[31:28], jump_index, 2'b00}.
  - branch_taken: pc<=pc4 + ({{14{branch_offset[15]}}, branch_offset, 2'b00}).
  - Sequential: pc<=pc4.
  - pc4 = pc+32'd4. All arithmetic is modulo 2^32 and wrap-around is silent (32'hFFFF_FFFC + 4 = 0).
- halt with exc in the same cycle: exc updates epc/pc, then the sequencer enters HALTED.
- HALTED: imem_req=0, instr_valid=0, halted=1. Only rst_n=0 exits this state.
- Control inputs are ignored in every state except ISSUE with stall=0.

## Timing
- Reset (rst_n=0 at an edge):
  - pc=RESET_VECTOR, epc=0, instr=0.
  - imem_req=0, instr_valid=0, halted=0, state=IDLE.
- Reset mid-FETCH or mid-ISSUE aborts the operation. imem_req drops the cycle after the reset edge, and a late imem_ack is ignored.
- First request: the first edge with rst_n=1 moves IDLE to FETCH, so imem_req=1 in the following cycle.
- Fetch latency: the edge where imem_ack=1 is sampled loads instr. instr_valid=1 from the next cycle.
- Zero-wait memory with no stalls gives one instruction every 2 cycles (FETCH, ISSUE).
- New pc_out and imem_req=1 appear in the cycle after the releasing edge (ISSUE with stall=0).
- The request may wait in FETCH any number of cycles. imem_addr stays constant until the ack edge.

## Test plan
- Reset and sequential fetch:
  - Stimulus: RESET_VECTOR=0, zero-wait ack, stall=0, instructions A,B,C.
  - Required: imem_addr 0,4,8 on alternate cycles; instr_valid pulses carrying A,B,C.
- Wait states and stall:
  - Stimulus: ack delayed 3 cycles, then stall held 4 cycles.
  - Required: imem_req held 4 cycles at a constant address; instr and instr_valid held 4 cycles; pc advances by 4 only after stall drops.
- Branch/jump arithmetic:
  - pc=0x100 with offset 16'hFFFE → next 0x0FC.
  - pc=0x100 with offset 16'h0003 → next 0x110.
  - pc=0x3000_0000 with jump_index=26'h1 → next 0x3000_0004.
  - jump and branch_taken together → jump target.
- Exception priority:
  - Stimulus: pc=0x40 with exc=1, jump=1, branch_taken=1 in the same cycle.
  - Required: epc=0x40 and next imem_addr=0x80.
- Halt and wrap:
  - pc=32'hFFFF_FFFC sequential → next fetch at 0.
  - halt=1 → halted=1 and imem_req stays 0 for 10+ cycles.
  - rst_n=0 → pc=RESET_VECTOR and halted=0.
- Reset mid-fetch:
  - Stimulus: assert rst_n=0 while in FETCH, then present imem_ack one cycle later.
  - Required: instr stays 0, instr_valid stays 0, and the sequencer restarts from IDLE.
